booth_r4_seq_mul: RTL and testbench

Iterative 32x32 radix-4 Booth multiplier controller. It owns one external 34-bit Booth partial-product generator (PPG) and drives one Booth digit into it per cycle. It accumulates the returned partial products, with the +1 negation correction, into a 64-bit product. It sits between an issue stage (valid/ready in) and a writeback stage (valid/ready out), and is the low-area alternative to the full PPG array.

---
 rtl/booth_r4_seq_mul.sv | 112 +++++++++++
 tb/tb_booth_r4_seq_mul.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_seq_mul.sv
// Iterative 32x32 radix-4 Booth multiplier controller: drives one Booth digit per cycle into an
// external 34-bit partial-product generator and accumulates the results into a 64-bit product.
module booth_r4_seq_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mulcand,
    input  logic [31:0] mulplier,
    input  logic        sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic [31:0] ppg_mulcand,
    output logic [2:0]  ppg_r4input,
    output logic        ppg_sign,
    input  logic [33:0] ppg_pp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [65:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic [34:0] y_q, y_d;
    logic [31:0] mcand_q, mcand_d;
    logic        sign_q, sign_d;

    logic        ext;
    logic        last_iter;
    logic [5:0]  shamt;
    logic [65:0] pp_term;
    logic [65:0] corr_term;

    assign ext       = sign & mulplier[31];
    assign last_iter = (count_q == (sign_q ? 5'd15 : 5'd16));
    assign shamt     = {count_q, 1'b0};

    // Negative digits arrive as one's complement; the +1 correction lands at the same weight.
    assign pp_term   = {{32{ppg_pp[33]}}, ppg_pp} << shamt;
    assign corr_term = 66'(ppg_r4input[2]) << shamt;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = acc_q[63:0];

    // PPG is held at zero outside RUN so it does not toggle while idle.
    always_comb begin
        ppg_mulcand = '0;
        ppg_r4input = '0;
        ppg_sign    = 1'b0;
        if (state_q == RUN) begin
            ppg_mulcand = mcand_q;
            ppg_r4input = y_q[2:0];
            ppg_sign    = sign_q;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        y_d     = y_q;
        mcand_d = mcand_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = mulcand;
                    sign_d  = sign;
                    y_d     = {ext, ext, mulplier, 1'b0};
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_q + pp_term + corr_term;
                y_d     = {{2{y_q[34]}}, y_q[34:2]};
                count_d = count_q + 5'd1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            y_q     <= '0;
            mcand_q <= '0;
            sign_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            y_q     <= y_d;
            mcand_q <= mcand_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed bench for booth_r4_seq_mul: models the external Booth PPG and checks products,
// latency, backpressure, ignored requests and asynchronous reset.
module tb_booth_r4_seq_mul;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mulcand;
    logic [31:0] mulplier;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic [31:0] ppg_mulcand;
    logic [2:0]  ppg_r4input;
    logic        ppg_sign;
    logic [33:0] ppg_pp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] mc;
        logic [31:0] mp;
        logic        sg;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    booth_r4_seq_mul dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mulcand     (mulcand),
        .mulplier    (mulplier),
        .sign        (sign),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .ppg_mulcand (ppg_mulcand),
        .ppg_r4input (ppg_r4input),
        .ppg_sign    (ppg_sign),
        .ppg_pp      (ppg_pp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Booth PPG: |digit| * M, one's complemented for negative digits.
    logic [33:0] m34;
    logic [33:0] mag;
    always_comb begin
        m34 = ppg_sign ? {{2{ppg_mulcand[31]}}, ppg_mulcand} : {2'b00, ppg_mulcand};
        mag = '0;
        case (ppg_r4input)
            3'b001, 3'b010, 3'b101, 3'b110: mag = m34;
            3'b011, 3'b100:                 mag = m34 << 1;
            default:                        mag = '0;
        endcase
        ppg_pp = ppg_r4input[2] ? ~mag : mag;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one request; returns at the negedge right after the accept edge.
    task automatic start_op(input logic [31:0] mc, input logic [31:0] mp, input logic sg,
                            input string name);
        @(negedge clk);
        mulcand  = mc;
        mulplier = mp;
        sign     = sg;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " in_ready low in RUN"}, 64'(in_ready), 64'd0);
        check({name, " ppg_mulcand"}, 64'(ppg_mulcand), 64'(mc));
        check({name, " ppg_r4input first"}, 64'(ppg_r4input), 64'({mp[1:0], 1'b0}));
        check({name, " ppg_sign"}, 64'(ppg_sign), 64'(sg));
    endtask

    // Called at the negedge after the accept edge; counts edges until out_valid.
    task automatic wait_done(input int exp_lat, input logic [63:0] exp_prod, input string name);
        int lat = 0;
        check({name, " out_valid low after accept"}, 64'(out_valid), 64'd0);
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " product"}, product, exp_prod);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " in_ready after handshake"}, 64'(in_ready), 64'd1);
        check({name, " out_valid after handshake"}, 64'(out_valid), 64'd0);
        check({name, " ppg idle"}, 64'({ppg_mulcand, ppg_r4input}), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        check({name, " out_valid"}, 64'(out_valid), 64'd0);
        check({name, " product"}, product, 64'd0);
        check({name, " ppg_mulcand"}, 64'(ppg_mulcand), 64'd0);
        check({name, " ppg_r4input"}, 64'(ppg_r4input), 64'd0);
        check({name, " ppg_sign"}, 64'(ppg_sign), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F, 17};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 16};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 16};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 16};
        vecs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 17};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, 17};
        vecs[6]  = '{32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 16};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, 17};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, 16};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 17};
        vecs[10] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0001, 16};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mulcand   = '0;
        mulplier  = '0;
        sign      = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Backpressure: product and out_valid stay put while out_ready is low.
        start_op(32'd3, 32'd5, 1'b0, "bp");
        wait_done(17, 64'h0F, "bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp hold%0d product", i), product, 64'h0F);
            check($sformatf("bp hold%0d in_ready", i), 64'(in_ready), 64'd0);
        end
        handshake("bp");

        for (int v = 0; v < 11; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            start_op(vecs[v].mc, vecs[v].mp, vecs[v].sg, nm);
            wait_done(vecs[v].lat, vecs[v].exp, nm);
            handshake(nm);
        end

        // in_valid held with other operands during RUN/DONE: ignored until the handshake.
        start_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "hold");
        mulcand  = 32'd3;
        mulplier = 32'd5;
        sign     = 1'b0;
        in_valid = 1'b1;
        wait_done(16, 64'hC000_0000_8000_0000, "hold");
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold in_ready after handshake", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold second accepted", 64'(in_ready), 64'd0);
        wait_done(17, 64'h0F, "hold2");
        handshake("hold2");

        // Asynchronous reset partway through RUN discards the partial result.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "rst");
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst async");
        @(negedge clk);
        check("rst held out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        start_op(32'd6, 32'd7, 1'b1, "post_rst");
        wait_done(16, 64'h2A, "post_rst");
        handshake("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
